// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - shared defaults and pointer sizing for the DES stub player
package des_pkg;

  localparam int DES_DATA_W  = 64;
  localparam int DES_DEPTH   = 16;
  localparam int DES_LATENCY = 1;

  // One extra bit lets a pointer distinguish "empty" from "full"
  function automatic int des_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/des_delay_line.sv
// rtl/des_delay_line.sv - LATENCY-1 register stages for a valid flag and its data;
// the top's output register supplies the last stage, so LATENCY=1 is a pass-through.
module des_delay_line #(
  parameter int WIDTH   = 64,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  generate
    if (LATENCY <= 1) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ reset;
      assign out_valid = in_valid;
      assign out_data  = in_data;
    end else begin : g_pipe
      localparam int STAGES = LATENCY - 1;
      logic [STAGES-1:0] vld;
      logic [WIDTH-1:0]  dat [STAGES];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          vld <= '0;
          for (int i = 0; i < STAGES; i++) dat[i] <= '0;
        end else begin
          vld[0] <= in_valid;
          dat[0] <= in_data;
          for (int i = 1; i < STAGES; i++) begin
            vld[i] <= vld[i-1];
            dat[i] <= dat[i-1];
          end
        end
      end

      assign out_valid = vld[STAGES-1];
      assign out_data  = dat[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/des_stub_player.sv
// rtl/des_stub_player.sv - DES stand-in that replays programmed result vectors per load.
// Optional macro DES_STUB_WRAP_EN: replay the stored vectors cyclically instead of exhausting.
module des_stub_player
  import des_pkg::*;
#(
  parameter int DATA_W  = DES_DATA_W,
  parameter int DEPTH   = DES_DEPTH,
  parameter int LATENCY = DES_LATENCY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] key_in,
  input  logic              prog_en,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [DATA_W-1:0] tag_out,
  output logic              done,
  output logic              prog_ovf
);

  localparam int PW    = des_ptr_w(DEPTH);
  localparam int IDX_W = PW - 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  logic unused_key;
  assign unused_key = ^key_in;

  logic              mat_vld;
  logic [DATA_W-1:0] mat_data;

  des_delay_line #(
    .WIDTH   (DATA_W),
    .LATENCY (LATENCY)
  ) u_delay (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (load),
    .in_data   (data_in),
    .out_valid (mat_vld),
    .out_data  (mat_data)
  );

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     vec_cnt;
  logic [PW-1:0]     rd_nxt;
  logic              serve;
  logic              push_ok;

  // Both decisions use the registered vec_cnt, so a same-cycle push is not yet visible
  assign serve   = mat_vld && !done && (rd_ptr < vec_cnt);
  assign push_ok = prog_en && (vec_cnt < DEPTH_P);

`ifdef DES_STUB_WRAP_EN
  assign rd_nxt = (rd_ptr + PW'(1) == vec_cnt) ? '0 : rd_ptr + PW'(1);
`else
  assign rd_nxt = rd_ptr + PW'(1);
`endif

  // Vector storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (push_ok) mem[vec_cnt[IDX_W-1:0]] <= prog_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr    <= '0;
      vec_cnt   <= '0;
      data_out  <= '0;
      tag_out   <= '0;
      valid_out <= 1'b0;
      done      <= 1'b0;
      prog_ovf  <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (serve) begin
        data_out  <= mem[rd_ptr[IDX_W-1:0]];
        tag_out   <= mat_data;
        valid_out <= 1'b1;
        rd_ptr    <= rd_nxt;
      end else if (mat_vld) begin
        done <= 1'b1;
      end
      if (push_ok) begin
        vec_cnt <= vec_cnt + PW'(1);
      end else if (prog_en) begin
        prog_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_des_stub_player.sv
// tb/tb_des_stub_player.sv - directed self-checking bench for des_stub_player
module tb_des_stub_player;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] key = 64'hDEAD_BEEF_CAFE_F00D;

  always #5 clk = ~clk;

  // instance a: LATENCY=1, DEPTH=16
  logic a_load = 0, a_prog_en = 0, a_valid, a_done, a_ovf;
  logic [63:0] a_din = '0, a_pd = '0, a_dout, a_tag;
  // instance b: LATENCY=4, DEPTH=16
  logic b_load = 0, b_prog_en = 0, b_valid, b_done, b_ovf;
  logic [63:0] b_din = '0, b_pd = '0, b_dout, b_tag;
  // instance c: LATENCY=1, DEPTH=2
  logic c_load = 0, c_prog_en = 0, c_valid, c_done, c_ovf;
  logic [63:0] c_din = '0, c_pd = '0, c_dout, c_tag;

  des_stub_player #(.DATA_W(64), .DEPTH(16), .LATENCY(1)) u_a (
    .clk(clk), .reset(rst), .load(a_load), .data_in(a_din), .key_in(key),
    .prog_en(a_prog_en), .prog_data(a_pd), .data_out(a_dout), .valid_out(a_valid),
    .tag_out(a_tag), .done(a_done), .prog_ovf(a_ovf));

  des_stub_player #(.DATA_W(64), .DEPTH(16), .LATENCY(4)) u_b (
    .clk(clk), .reset(rst), .load(b_load), .data_in(b_din), .key_in(key),
    .prog_en(b_prog_en), .prog_data(b_pd), .data_out(b_dout), .valid_out(b_valid),
    .tag_out(b_tag), .done(b_done), .prog_ovf(b_ovf));

  des_stub_player #(.DATA_W(64), .DEPTH(2), .LATENCY(1)) u_c (
    .clk(clk), .reset(rst), .load(c_load), .data_in(c_din), .key_in(key),
    .prog_en(c_prog_en), .prog_data(c_pd), .data_out(c_dout), .valid_out(c_valid),
    .tag_out(c_tag), .done(c_done), .prog_ovf(c_ovf));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [63:0] vec_a [3] = '{64'hAAAA_0000_0000_0001, 64'hBBBB_0000_0000_0002, 64'hCCCC_0000_0000_0003};
  logic [63:0] tag_a [4] = '{64'h7000_0000_0000_0010, 64'h7000_0000_0000_0011,
                             64'h7000_0000_0000_0012, 64'h7000_0000_0000_0020};
  logic [63:0] vec_b [4] = '{64'h5555_6666_7777_8888, 64'h1, 64'h2, 64'h3};
  logic [63:0] vec_c [3] = '{64'hC0C0_0000_0000_000A, 64'hC0C0_0000_0000_000B, 64'hC0C0_0000_0000_000C};
  logic [63:0] exp_c_dout [5];
  logic        exp_c_vld  [5];
  logic        exp_c_done [5];
  int          pulses;

  initial begin
`ifdef DES_STUB_WRAP_EN
    exp_c_dout = '{vec_c[0], vec_c[1], vec_c[0], vec_c[1], vec_c[0]};
    exp_c_vld  = '{1, 1, 1, 1, 1};
    exp_c_done = '{0, 0, 0, 0, 0};
`else
    exp_c_dout = '{vec_c[0], vec_c[1], vec_c[1], vec_c[1], vec_c[1]};
    exp_c_vld  = '{1, 1, 0, 0, 0};
    exp_c_done = '{0, 0, 1, 1, 1};
`endif

    // reset state
    repeat (2) @(negedge clk);
    check("rst_valid", {63'd0, a_valid}, 64'd0);
    check("rst_done", {63'd0, a_done}, 64'd0);
    check("rst_ovf", {63'd0, a_ovf}, 64'd0);
    check("rst_dout", a_dout, 64'd0);
    check("rst_tag", a_tag, 64'd0);
    check("rst_b_valid", {63'd0, b_valid}, 64'd0);
    rst = 1'b0;

    // load matures in the same cycle as the first push into an empty store
    @(negedge clk);
    a_load = 1; a_din = 64'h1234; a_prog_en = 1; a_pd = vec_a[0];
    @(negedge clk);
    a_load = 0; a_prog_en = 0;
    check("same_cycle_valid", {63'd0, a_valid}, 64'd0);
    check("same_cycle_done", {63'd0, a_done}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst2_done", {63'd0, a_done}, 64'd0);
    rst = 1'b0;

    // three vectors, three back-to-back loads, then an exhausting fourth load
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a_prog_en = 1; a_pd = vec_a[i];
    end
    @(negedge clk);
    a_prog_en = 0;
    for (int i = 0; i < 3; i++) begin
      a_load = 1; a_din = tag_a[i];
      @(negedge clk);
      check($sformatf("a_valid%0d", i), {63'd0, a_valid}, 64'd1);
      check($sformatf("a_dout%0d", i), a_dout, vec_a[i]);
      check($sformatf("a_tag%0d", i), a_tag, tag_a[i]);
    end
    a_load = 0;
    @(negedge clk);
    check("a_pulse_end", {63'd0, a_valid}, 64'd0);
    check("a_hold_dout", a_dout, vec_a[2]);
    check("a_not_done", {63'd0, a_done}, 64'd0);
    repeat (3) @(negedge clk);
    a_load = 1; a_din = tag_a[3];
    @(negedge clk);
    a_load = 0;
`ifdef DES_STUB_WRAP_EN
    check("a4_valid", {63'd0, a_valid}, 64'd1);
    check("a4_dout", a_dout, vec_a[0]);
    check("a4_done", {63'd0, a_done}, 64'd0);
`else
    check("a4_valid", {63'd0, a_valid}, 64'd0);
    check("a4_done", {63'd0, a_done}, 64'd1);
    check("a4_dout", a_dout, vec_a[2]);
    check("a4_tag", a_tag, tag_a[2]);
`endif

    // LATENCY=4: valid_out exactly four cycles after the load
    @(negedge clk);
    b_prog_en = 1; b_pd = vec_b[0];
    @(negedge clk);
    b_prog_en = 0;
    b_load = 1; b_din = 64'h0123456789ABCDEF;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      b_load = 0;
      if (k < 4) begin
        check($sformatf("b_early%0d", k), {63'd0, b_valid}, 64'd0);
      end else begin
        check("b_valid", {63'd0, b_valid}, 64'd1);
        check("b_tag", b_tag, 64'h0123456789ABCDEF);
        check("b_dout", b_dout, vec_b[0]);
      end
    end
    @(negedge clk);
    check("b_pulse_end", {63'd0, b_valid}, 64'd0);

    // reset with three loads in flight
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      b_prog_en = 1; b_pd = vec_b[i];
    end
    @(negedge clk);
    b_prog_en = 0;
    for (int i = 0; i < 3; i++) begin
      b_load = 1; b_din = 64'hF0 + 64'(i);
      @(negedge clk);
    end
    b_load = 0;
    rst = 1'b1;
    #1;
    check("b_rst_dout", b_dout, 64'd0);
    check("b_rst_tag", b_tag, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (b_valid) pulses++;
    end
    check("b_no_valid_after_rst", 64'(pulses), 64'd0);
    check("b_post_dout", b_dout, 64'd0);
    check("b_post_done", {63'd0, b_done}, 64'd0);
    check("b_post_ovf", {63'd0, b_ovf}, 64'd0);

    // DEPTH=2: third push overflows and leaves the store unchanged
    @(negedge clk);
    c_prog_en = 1; c_pd = vec_c[0];
    @(negedge clk);
    c_pd = vec_c[1];
    @(negedge clk);
    c_pd = vec_c[2];
    check("c_ovf_before", {63'd0, c_ovf}, 64'd0);
    @(negedge clk);
    c_prog_en = 0;
    check("c_ovf_after", {63'd0, c_ovf}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      c_load = 1; c_din = 64'hE0 + 64'(i);
      @(negedge clk);
      check($sformatf("c_valid%0d", i), {63'd0, c_valid}, {63'd0, exp_c_vld[i]});
      check($sformatf("c_dout%0d", i), c_dout, exp_c_dout[i]);
      check($sformatf("c_done%0d", i), {63'd0, c_done}, {63'd0, exp_c_done[i]});
    end
    c_load = 0;
    @(negedge clk);
    check("c_ovf_sticky", {63'd0, c_ovf}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
